// File: rtl/sell_settle_pkg.sv
// Shared types, widths and constants for the sell settlement block.
package sell_settle_pkg;

  localparam int QTY_W      = 8;
  localparam int PRICE_W    = 12;
  localparam int CASH_W     = 24;
  localparam int PROD_W     = QTY_W + PRICE_W;
  localparam int MUL_CYCLES = 8;

  localparam logic [CASH_W-1:0] CASH_SAT = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_MUL_A  = 3'd2,
    S_MUL_C  = 3'd3,
    S_COMMIT = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  // Add both proceeds to cash, clamping at the all-ones value.
  function automatic logic [CASH_W-1:0] sat_add(
    input logic [CASH_W-1:0] cash,
    input logic [PROD_W-1:0] proc_a,
    input logic [PROD_W-1:0] proc_c
  );
    logic [CASH_W:0] sum;
    sum = {1'b0, cash} + {5'd0, proc_a} + {5'd0, proc_c};
    if (sum[CASH_W]) begin
      return CASH_SAT;
    end else begin
      return sum[CASH_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sell_settle_shift_add_mul.sv
// Sequential 8x12 shift-add multiplier: start edge plus 7 more edges, done pulses
// for one cycle once the 20-bit product is final.
module shift_add_mul
  import sell_settle_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [QTY_W-1:0]   a,
  input  logic [PRICE_W-1:0] b,
  output logic [PROD_W-1:0]  product,
  output logic               done
);

  logic [PROD_W-1:0] mcand;
  logic [QTY_W-1:0]  mplier;
  logic [2:0]        cnt;
  logic              run;

  // The start edge already consumes multiplier bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= 20'd0;
      mcand   <= 20'd0;
      mplier  <= 8'd0;
      cnt     <= 3'd0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      product <= a[0] ? {8'd0, b} : 20'd0;
      mcand   <= {7'd0, b, 1'b0};
      mplier  <= {1'b0, a[QTY_W-1:1]};
      cnt     <= 3'd1;
      run     <= 1'b1;
      done    <= 1'b0;
    end else if (run) begin
      product <= product + (mplier[0] ? mcand : 20'd0);
      mcand   <= {mcand[PROD_W-2:0], 1'b0};
      mplier  <= {1'b0, mplier[QTY_W-1:1]};
      cnt     <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        run  <= 1'b0;
        done <= 1'b1;
      end else begin
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/sell_settle.sv
// Sell settlement: validates a sell request, prices both legs on one shared
// multiplier, then commits saturated cash and reduced holdings.
module sell_settle
  import sell_settle_pkg::*;
#(
  parameter logic [CASH_W-1:0] INIT_CASH  = 24'd1000,
  parameter logic [QTY_W-1:0]  INIT_QTY_A = 8'd10,
  parameter logic [QTY_W-1:0]  INIT_QTY_C = 8'd10
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               exit,
  input  logic [QTY_W-1:0]   stockA_sold,
  input  logic [QTY_W-1:0]   stockC_sold,
  input  logic [PRICE_W-1:0] stockA_price,
  input  logic [PRICE_W-1:0] stockC_price,
  input  logic               err_clear,
  output logic [QTY_W-1:0]   stockA_qty,
  output logic [QTY_W-1:0]   stockC_qty,
  output logic [CASH_W-1:0]  current_cash,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t             state;
  logic [QTY_W-1:0]   sold_a;
  logic [QTY_W-1:0]   sold_c;
  logic [PRICE_W-1:0] price_a;
  logic [PRICE_W-1:0] price_c;
  logic [PROD_W-1:0]  proc_a;
  logic [2:0]         cnt;
  logic               mul_start;
  logic               mul_done;
  logic [PROD_W-1:0]  mul_product;
  logic [QTY_W-1:0]   mul_a;
  logic [PRICE_W-1:0] mul_b;

  assign mul_a = (state == S_MUL_C) ? sold_c  : sold_a;
  assign mul_b = (state == S_MUL_C) ? price_c : price_a;

  shift_add_mul u_mul (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .product (mul_product),
    .done    (mul_done)
  );

  // Settlement FSM; the multiplier samples mul_start on the first edge of each MUL state.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      sold_a       <= 8'd0;
      sold_c       <= 8'd0;
      price_a      <= 12'd0;
      price_c      <= 12'd0;
      proc_a       <= 20'd0;
      cnt          <= 3'd0;
      mul_start    <= 1'b0;
      stockA_qty   <= INIT_QTY_A;
      stockC_qty   <= INIT_QTY_C;
      current_cash <= INIT_CASH;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (exit) begin
            sold_a  <= stockA_sold;
            sold_c  <= stockC_sold;
            price_a <= stockA_price;
            price_c <= stockC_price;
            busy    <= 1'b1;
            state   <= S_CHECK;
          end else begin
            busy <= 1'b0;
          end
        end
        S_CHECK: begin
          if ((sold_a > stockA_qty) || (sold_c > stockC_qty)) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            mul_start <= 1'b1;
            cnt       <= 3'd0;
            state     <= S_MUL_A;
          end
        end
        S_MUL_A: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'(MUL_CYCLES - 1)) begin
            mul_start <= 1'b1;
            cnt       <= 3'd0;
            state     <= S_MUL_C;
          end else begin
            mul_start <= 1'b0;
          end
        end
        S_MUL_C: begin
          mul_start <= 1'b0;
          cnt       <= cnt + 3'd1;
          // Leg A's product is still held on the edge the C multiply loads.
          if (mul_done) begin
            proc_a <= mul_product;
          end
          if (cnt == 3'(MUL_CYCLES - 1)) begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          current_cash <= sat_add(current_cash, proc_a, mul_product);
          stockA_qty   <= stockA_qty - sold_a;
          stockC_qty   <= stockC_qty - sold_c;
          busy         <= 1'b0;
          done         <= 1'b1;
          state        <= S_IDLE;
        end
        S_ERROR: begin
          busy <= 1'b0;
          if (err_clear) begin
            error <= 1'b0;
            state <= S_IDLE;
          end else begin
            error <= 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
          mul_start <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sell_settle.sv
// Directed bench for sell_settle: default instance plus a near-saturation instance.
module tb_sell_settle;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic        exit = 1'b0, err_clear = 1'b0;
  logic [7:0]  sold_a = 8'd0, sold_c = 8'd0;
  logic [11:0] price_a = 12'd0, price_c = 12'd0;
  logic [7:0]  qty_a, qty_c;
  logic [23:0] cash;
  logic        busy, done, error;

  logic        s_exit = 1'b0;
  logic [7:0]  s_sold_a = 8'd0;
  logic [11:0] s_price_a = 12'd0;
  logic [7:0]  s_qty_a, s_qty_c;
  logic [23:0] s_cash;
  logic        s_busy, s_done, s_error;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  sell_settle dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .exit(exit),
    .stockA_sold(sold_a), .stockC_sold(sold_c),
    .stockA_price(price_a), .stockC_price(price_c),
    .err_clear(err_clear),
    .stockA_qty(qty_a), .stockC_qty(qty_c), .current_cash(cash),
    .busy(busy), .done(done), .error(error)
  );

  sell_settle #(.INIT_CASH(24'hFFFF00)) dut_sat (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .exit(s_exit),
    .stockA_sold(s_sold_a), .stockC_sold(8'd0),
    .stockA_price(s_price_a), .stockC_price(12'd0),
    .err_clear(1'b0),
    .stockA_qty(s_qty_a), .stockC_qty(s_qty_c), .current_cash(s_cash),
    .busy(s_busy), .done(s_done), .error(s_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Pulse exit for one edge; returns in the CHECK cycle.
  task automatic launch(input logic [7:0] sa, input logic [11:0] pa,
                        input logic [7:0] sc, input logic [11:0] pc);
    sold_a = sa; price_a = pa; sold_c = sc; price_c = pc;
    exit = 1'b1;
    tick();
    exit = 1'b0;
  endtask

  // done must stay low through the 18th cycle and rise in the 19th.
  task automatic expect_done(input string tag);
    logic early;
    early = 1'b0;
    repeat (17) begin
      tick();
      if (done) early = 1'b1;
    end
    chk({tag, "_done_early"}, {31'd0, early}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic seen;

    // Reset state
    @(negedge CLOCK_50);
    chk("rst_cash", {8'd0, cash}, 32'd1000);
    chk("rst_qty_a", {24'd0, qty_a}, 32'd10);
    chk("rst_qty_c", {24'd0, qty_c}, 32'd10);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    chk("rst_sat_cash", {8'd0, s_cash}, 32'h00FFFF00);
    resetn = 1'b1;
    tick();

    // 4 x 25 on A, nothing on C
    launch(8'd4, 12'd25, 8'd0, 12'd0);
    chk("a_busy_check", {31'd0, busy}, 32'd1);
    expect_done("a");
    chk("a_cash", {8'd0, cash}, 32'd1100);
    chk("a_qty_a", {24'd0, qty_a}, 32'd6);
    chk("a_qty_c", {24'd0, qty_c}, 32'd10);
    chk("a_busy_end", {31'd0, busy}, 32'd0);
    tick();
    chk("a_done_one_cycle", {31'd0, done}, 32'd0);

    // Both legs: 3x100 + 2x50
    do_reset();
    launch(8'd3, 12'd100, 8'd2, 12'd50);
    expect_done("ac");
    chk("ac_cash", {8'd0, cash}, 32'd1400);
    chk("ac_qty_a", {24'd0, qty_a}, 32'd7);
    chk("ac_qty_c", {24'd0, qty_c}, 32'd8);

    // Zero quantities still complete with nothing changed
    launch(8'd0, 12'd500, 8'd0, 12'd500);
    expect_done("zero");
    chk("zero_cash", {8'd0, cash}, 32'd1400);
    chk("zero_qty", {16'd0, qty_a, qty_c}, {16'd0, 8'd7, 8'd8});

    // Oversell -> ERROR; exit ignored there; err_clear leaves
    do_reset();
    launch(8'd11, 12'd5, 8'd0, 12'd0);
    tick();
    chk("err_flag", {31'd0, error}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    launch(8'd1, 12'd5, 8'd0, 12'd0);
    tick();
    chk("err_exit_ignored", {30'd0, busy, error}, 32'd1);
    chk("err_cash", {8'd0, cash}, 32'd1000);
    chk("err_qty", {16'd0, qty_a, qty_c}, {16'd0, 8'd10, 8'd10});
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("err_cleared", {31'd0, error}, 32'd0);
    tick();
    chk("err_idle", {30'd0, busy, error}, 32'd0);

    // Second exit during MUL_A is ignored: 2x10 + 1x20 only
    launch(8'd2, 12'd10, 8'd1, 12'd20);
    tick();
    tick();
    sold_a = 8'd5; price_a = 12'd100; sold_c = 8'd5; price_c = 12'd100;
    exit = 1'b1;
    tick();
    exit = 1'b0;
    repeat (14) tick();
    chk("dbl_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("dbl_done", {31'd0, done}, 32'd1);
    chk("dbl_cash", {8'd0, cash}, 32'd1040);
    chk("dbl_qty", {16'd0, qty_a, qty_c}, {16'd0, 8'd8, 8'd9});
    tick();
    chk("dbl_no_rerun", {31'd0, busy}, 32'd0);

    // Reset during MUL_C discards everything
    launch(8'd1, 12'd10, 8'd1, 12'd10);
    repeat (12) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_cash", {8'd0, cash}, 32'd1000);
    chk("mid_rst_qty", {16'd0, qty_a, qty_c}, {16'd0, 8'd10, 8'd10});
    chk("mid_rst_flags", {29'd0, busy, done, error}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("mid_no_done", {31'd0, seen}, 32'd0);
    chk("mid_cash_after", {8'd0, cash}, 32'd1000);

    // Saturation: FFFF00 + 10 x 4095
    s_sold_a = 8'd10; s_price_a = 12'd4095;
    s_exit = 1'b1;
    tick();
    s_exit = 1'b0;
    seen = 1'b0;
    repeat (17) begin
      tick();
      if (s_done) seen = 1'b1;
    end
    chk("sat_done_early", {31'd0, seen}, 32'd0);
    tick();
    chk("sat_done", {31'd0, s_done}, 32'd1);
    chk("sat_cash", {8'd0, s_cash}, 32'h00FFFFFF);
    chk("sat_qty_a", {24'd0, s_qty_a}, 32'd0);
    chk("sat_qty_c", {24'd0, s_qty_c}, 32'd10);
    chk("sat_error", {31'd0, s_error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
